// File: rtl/rock_level_ctrl.sv
// Rocking intensity controller: judges fixed observation windows of the
// stress-decrease flag and steps the motor level up, down or holds it.
module rock_level_ctrl #(
  parameter int WINDOW        = 16,
  parameter int GOOD_THRESH   = 4,
  parameter int SETTLE        = 8,
  parameter int CALM_WINDOWS  = 3,
  parameter int ALARM_WINDOWS = 2,
  parameter int MAX_LEVEL     = 7
) (
  input  logic       clk,
  input  logic       r,
  input  logic       en,
  input  logic       stress_laag,
  output logic [2:0] level,
  output logic       level_change,
  output logic       alarm
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int WW = $clog2(WINDOW) + 1;
  localparam int GW = (CALM_WINDOWS > 1) ? $clog2(CALM_WINDOWS) : 1;
  localparam int BW = $clog2(ALARM_WINDOWS + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [SW-1:0] S_ONE       = SW'(1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
  localparam logic [WW-1:0] GOOD_T      = WW'(GOOD_THRESH);
  localparam logic [WW-1:0] W_ONE       = WW'(1);
  localparam logic [GW-1:0] CALM_LAST   = GW'(CALM_WINDOWS - 1);
  localparam logic [GW-1:0] G_ONE       = GW'(1);
  localparam logic [BW-1:0] ALARM_LAST  = BW'(ALARM_WINDOWS - 1);
  localparam logic [BW-1:0] ALARM_MAX   = BW'(ALARM_WINDOWS);
  localparam logic [BW-1:0] B_ONE       = BW'(1);
  localparam logic [2:0]    MAX_LVL     = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WINDOW = 2'd2,
    S_DECIDE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    level_q, level_d;
  logic          level_change_q, level_change_d;
  logic          alarm_q, alarm_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [WW-1:0] win_q, win_d;
  logic [WW-1:0] hits_q, hits_d;
  logic [GW-1:0] good_q, good_d;
  logic [BW-1:0] bad_q, bad_d;

  // Next-state and output decode; disable overrides every state.
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    level_change_d = 1'b0;
    alarm_d        = alarm_q;
    settle_d       = settle_q;
    win_d          = win_q;
    hits_d         = hits_q;
    good_d         = good_q;
    bad_d          = bad_q;
    if (!en) begin
      state_d        = S_IDLE;
      level_d        = 3'd0;
      level_change_d = (level_q != 3'd0);
      alarm_d        = 1'b0;
      settle_d       = '0;
      win_d          = '0;
      hits_d         = '0;
      good_d         = '0;
      bad_d          = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          level_d        = 3'd1;
          level_change_d = 1'b1;
          settle_d       = '0;
          state_d        = S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = S_WINDOW;
            win_d   = '0;
            hits_d  = '0;
          end else begin
            settle_d = settle_q + S_ONE;
          end
        end
        S_WINDOW: begin
          hits_d = hits_q + {{(WW-1){1'b0}}, stress_laag};
          if (win_q == WIN_LAST) begin
            state_d = S_DECIDE;
          end else begin
            win_d = win_q + W_ONE;
          end
        end
        S_DECIDE: begin
          win_d    = '0;
          hits_d   = '0;
          settle_d = '0;
          if (hits_q >= GOOD_T) begin
            bad_d   = '0;
            alarm_d = 1'b0;
            if ((good_q == CALM_LAST) && (level_q > 3'd1)) begin
              level_d        = level_q - 3'd1;
              level_change_d = 1'b1;
              good_d         = '0;
              state_d        = S_SETTLE;
            end else begin
              // At level 1 the calm streak holds at its ceiling instead of wrapping.
              if (good_q == CALM_LAST) begin
                good_d = good_q;
              end else begin
                good_d = good_q + G_ONE;
              end
              state_d = S_WINDOW;
            end
          end else begin
            good_d = '0;
            if (level_q < MAX_LVL) begin
              level_d        = level_q + 3'd1;
              level_change_d = 1'b1;
              bad_d          = '0;
              state_d        = S_SETTLE;
            end else begin
              if (bad_q == ALARM_MAX) begin
                bad_d = bad_q;
              end else begin
                bad_d = bad_q + B_ONE;
              end
              if (bad_q >= ALARM_LAST) begin
                alarm_d = 1'b1;
              end else begin
                alarm_d = alarm_q;
              end
              state_d = S_WINDOW;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          level_d = 3'd0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q        <= S_IDLE;
      level_q        <= 3'd0;
      level_change_q <= 1'b0;
      alarm_q        <= 1'b0;
      settle_q       <= '0;
      win_q          <= '0;
      hits_q         <= '0;
      good_q         <= '0;
      bad_q          <= '0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      level_change_q <= level_change_d;
      alarm_q        <= alarm_d;
      settle_q       <= settle_d;
      win_q          <= win_d;
      hits_q         <= hits_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
    end
  end

  assign level        = level_q;
  assign level_change = level_change_q;
  assign alarm        = alarm_q;

endmodule

// File: tb/tb_rock_level_ctrl.sv
// Bench for rock_level_ctrl: edge-by-edge comparison against a decision-time
// model that sums the sample history over each window.
module tb_rock_level_ctrl;

  localparam int WINDOW        = 16;
  localparam int GOOD_THRESH   = 4;
  localparam int SETTLE        = 8;
  localparam int CALM_WINDOWS  = 3;
  localparam int ALARM_WINDOWS = 2;
  localparam int MAX_LEVEL     = 7;

  logic       clk;
  logic       r;
  logic       en;
  logic       stress_laag;
  logic [2:0] level;
  logic       level_change;
  logic       alarm;

  rock_level_ctrl #(
    .WINDOW(WINDOW), .GOOD_THRESH(GOOD_THRESH), .SETTLE(SETTLE),
    .CALM_WINDOWS(CALM_WINDOWS), .ALARM_WINDOWS(ALARM_WINDOWS), .MAX_LEVEL(MAX_LEVEL)
  ) dut (
    .clk(clk), .r(r), .en(en), .stress_laag(stress_laag),
    .level(level), .level_change(level_change), .alarm(alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: level, streaks, and the edge of the next decision.
  int m_lvl = 0, m_good = 0, m_bad = 0, m_next = 0, n = 0;
  bit m_alarm = 0, m_lc = 0, m_en = 0;
  bit hist [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s at edge %0d: observed %0d expected %0d", tag, n - 1, obs, exp);
  endtask

  task automatic decide(input int hits);
    bit changed;
    changed = 0;
    if (hits >= GOOD_THRESH) begin
      m_bad = 0;
      m_alarm = 0;
      if (m_good + 1 == CALM_WINDOWS && m_lvl > 1) begin
        m_lvl--; m_lc = 1; m_good = 0; changed = 1;
      end else if (m_lvl == 1) begin
        m_good = (m_good + 1 > CALM_WINDOWS - 1) ? CALM_WINDOWS - 1 : m_good + 1;
      end else begin
        m_good++;
      end
    end else begin
      m_good = 0;
      if (m_lvl < MAX_LEVEL) begin
        m_lvl++; m_lc = 1; m_bad = 0; changed = 1;
      end else begin
        m_bad = (m_bad + 1 > ALARM_WINDOWS) ? ALARM_WINDOWS : m_bad + 1;
        if (m_bad >= ALARM_WINDOWS) m_alarm = 1;
      end
    end
    m_next = n + (changed ? SETTLE + WINDOW + 1 : WINDOW + 1);
  endtask

  task automatic step(input logic r_v, input logic en_v, input logic st_v);
    int hits;
    @(negedge clk);
    r = r_v; en = en_v; stress_laag = st_v;
    @(posedge clk);
    m_lc = 0;
    if (r_v) begin
      m_lvl = 0; m_alarm = 0; m_good = 0; m_bad = 0; m_en = 0;
    end else if (!en_v) begin
      m_lc = (m_lvl != 0);
      m_lvl = 0; m_alarm = 0; m_good = 0; m_bad = 0; m_en = 0;
    end else if (!m_en) begin
      m_en = 1; m_lvl = 1; m_lc = 1; m_good = 0; m_bad = 0;
      m_next = n + SETTLE + WINDOW + 1;
    end else if (n == m_next) begin
      hits = 0;
      for (int k = 1; k <= WINDOW; k++) hits += int'(hist[(n - k) % 64]);
      decide(hits);
    end
    hist[n % 64] = st_v;
    n++;
    #1;
    chk("level", {29'd0, level}, m_lvl);
    chk("level_change", {31'd0, level_change}, {31'd0, m_lc});
    chk("alarm", {31'd0, alarm}, {31'd0, m_alarm});
    // glitch between edges; only the edge value may count
    stress_laag = ~st_v;
  endtask

  initial begin
    r = 1'b1; en = 1'b0; stress_laag = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    // never calming: climb to the top level and raise the alarm
    repeat (260) step(1'b0, 1'b1, 1'b0);
    // strong calming clears the alarm
    repeat (40) step(1'b0, 1'b1, 1'b1);
    // 2-3 hits per window: always bad
    for (int i = 0; i < 400; i++) step(1'b0, 1'b1, (i % 6) == 0);
    // exactly 4 hits in any 16 samples: step down to 1 and hold there
    for (int i = 0; i < 700; i++) step(1'b0, 1'b1, (i % 4) == 0);
    for (int i = 0; i < 90; i++) step(1'b0, 1'b1, (i % 6) == 0);
    // abort mid-window, then re-enable with a quiet stream
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b1, 1'b0);
    // randomized tail with rare disables and resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(999, 0) == 0), ($urandom_range(399, 0) != 0),
           ($urandom_range(99, 0) < 27));
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
